// File: rtl/sparc_pkg.sv
// Shared fetch-stage definitions: reset PC, squash NOP encoding and the fetch FSM states.
package sparc_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0100_0000;  // sethi 0,%g0
   localparam logic [31:0] WORD_INC = 32'd4;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StPend   = 2'd1,
      StSquash = 2'd2
   } fetch_state_e;

   // Instruction addresses are word aligned; low bits of a target are discarded.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_npc_reg.sv
// PC/nPC pair with a pending-redirect latch that holds a redirect resolved during a PC stall.
module pc_npc_reg
   import sparc_pkg::*;
#(
   parameter logic [31:0] ResetPc = RESET_PC
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        le_pc_i,
   input  logic        redirect_i,
   input  logic [31:0] target_i,
   input  logic        annul_i,
   output logic [31:0] pc_o,
   output logic [31:0] npc_o,
   output logic        apply_o,
   output logic        apply_annul_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  npc_q, npc_d;
   logic [31:0]  pend_tgt_q, pend_tgt_d;
   logic         pend_annul_q, pend_annul_d;

   logic         eff_redirect;
   logic [31:0]  eff_tgt;
   logic         eff_annul;

   // A live redirect takes precedence over the latched one.
   always_comb begin
      eff_redirect = redirect_i || (state_q == StPend);
      eff_tgt      = redirect_i ? align_word(target_i) : pend_tgt_q;
      eff_annul    = redirect_i ? annul_i : pend_annul_q;
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      npc_d        = npc_q;
      pend_tgt_d   = pend_tgt_q;
      pend_annul_d = pend_annul_q;
      if (le_pc_i) begin
         if (eff_redirect) begin
            pc_d    = eff_tgt;
            npc_d   = eff_tgt + WORD_INC;
            state_d = StRun;
         end else begin
            pc_d  = npc_q;
            npc_d = npc_q + WORD_INC;
         end
      end else if (redirect_i) begin
         pend_tgt_d   = eff_tgt;
         pend_annul_d = annul_i;
         state_d      = StPend;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StRun;
         pc_q         <= ResetPc;
         npc_q        <= ResetPc + WORD_INC;
         pend_tgt_q   <= '0;
         pend_annul_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         npc_q        <= npc_d;
         pend_tgt_q   <= pend_tgt_d;
         pend_annul_q <= pend_annul_d;
      end
   end

   assign pc_o          = pc_q;
   assign npc_o         = npc_q;
   assign apply_o       = le_pc_i && eff_redirect;
   assign apply_annul_o = apply_o && eff_annul;

endmodule

// File: rtl/fetch_pc_unit.sv
// SPARC instruction-fetch stage: PC/nPC sequencing, delayed-branch redirects with annulled
// delay slots, and the IF/ID pipeline register.
module fetch_pc_unit
   import sparc_pkg::*;
#(
   parameter logic [31:0] ResetPc = RESET_PC,
   parameter logic [31:0] NopWord = NOP_WORD
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        le_pc_i,
   input  logic        ifid_le_i,
   input  logic        redirect_i,
   input  logic [31:0] target_i,
   input  logic        annul_i,
   input  logic [31:0] imem_instr_i,
   output logic [31:0] imem_addr_o,
   output logic [31:0] pc_o,
   output logic [31:0] npc_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc_o,
   output logic [31:0] ifid_npc_o,
   output logic        ifid_valid_o
);

   logic [31:0]  pc;
   logic [31:0]  npc;
   logic         apply;
   logic         apply_annul;

   fetch_state_e sq_state_q, sq_state_d;
   logic         squash_now;
   logic [31:0]  ifid_instr_q, ifid_instr_d;
   logic [31:0]  ifid_pc_q, ifid_pc_d;
   logic [31:0]  ifid_npc_q, ifid_npc_d;
   logic         ifid_valid_q, ifid_valid_d;

   pc_npc_reg #(
      .ResetPc(ResetPc)
   ) u_pc_npc_reg (
      .clk_i        (clk_i),
      .rst_i        (reset_i),
      .le_pc_i      (le_pc_i),
      .redirect_i   (redirect_i),
      .target_i     (target_i),
      .annul_i      (annul_i),
      .pc_o         (pc),
      .npc_o        (npc),
      .apply_o      (apply),
      .apply_annul_o(apply_annul)
   );

   // An annul is owed either from this edge's applied redirect or from an earlier stalled load.
   always_comb begin
      unique case (sq_state_q)
         StSquash: squash_now = 1'b1;
         default:  squash_now = apply_annul;
      endcase
   end

   always_comb begin
      sq_state_d   = sq_state_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_npc_d   = ifid_npc_q;
      ifid_valid_d = ifid_valid_q;
      if (ifid_le_i) begin
         ifid_pc_d  = pc;
         ifid_npc_d = npc;
         sq_state_d = StRun;
         if (squash_now) begin
            ifid_instr_d = NopWord;
            ifid_valid_d = 1'b0;
         end else begin
            ifid_instr_d = imem_instr_i;
            ifid_valid_d = 1'b1;
         end
      end else if (squash_now) begin
         sq_state_d = StSquash;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sq_state_q   <= StRun;
         ifid_instr_q <= NopWord;
         ifid_pc_q    <= '0;
         ifid_npc_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else begin
         sq_state_q   <= sq_state_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_npc_q   <= ifid_npc_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

   assign imem_addr_o  = pc;
   assign pc_o         = pc;
   assign npc_o        = npc;
   assign ifid_instr_o = ifid_instr_q;
   assign ifid_pc_o    = ifid_pc_q;
   assign ifid_npc_o   = ifid_npc_q;
   assign ifid_valid_o = ifid_valid_q;

   // Used only by the bench-visible assertion below to keep the FSM in its legal subset.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (sq_state_q != StPend);
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized bench for fetch_pc_unit against a behavioural fetch-stage model.
module tb_fetch_pc_unit;
   import sparc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        le_pc, ifid_le, redirect, annul;
   logic [31:0] target;
   logic [31:0] imem_instr, imem_addr, pc, npc;
   logic [31:0] ifid_instr, ifid_pc, ifid_npc;
   logic        ifid_valid;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the architectural state.
   logic [31:0] m_pc, m_npc, m_instr, m_ipc, m_inpc;
   logic        m_valid;
   logic        m_pend;
   logic [31:0] m_pend_tgt;
   logic        m_pend_annul;
   logic        m_owe_nop;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   assign imem_instr = mem_word(imem_addr);

   fetch_pc_unit dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .le_pc_i     (le_pc),
      .ifid_le_i   (ifid_le),
      .redirect_i  (redirect),
      .target_i    (target),
      .annul_i     (annul),
      .imem_instr_i(imem_instr),
      .imem_addr_o (imem_addr),
      .pc_o        (pc),
      .npc_o       (npc),
      .ifid_instr_o(ifid_instr),
      .ifid_pc_o   (ifid_pc),
      .ifid_npc_o  (ifid_npc),
      .ifid_valid_o(ifid_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"}, pc, m_pc);
      chk({tag, ".npc"}, npc, m_npc);
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      chk({tag, ".ifid_instr"}, ifid_instr, m_instr);
      chk({tag, ".ifid_pc"}, ifid_pc, m_ipc);
      chk({tag, ".ifid_npc"}, ifid_npc, m_inpc);
      chk({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
   endtask

   task automatic model_reset();
      m_pc         = RESET_PC;
      m_npc        = RESET_PC + 32'd4;
      m_instr      = NOP_WORD;
      m_ipc        = 32'd0;
      m_inpc       = 32'd0;
      m_valid      = 1'b0;
      m_pend       = 1'b0;
      m_pend_tgt   = 32'd0;
      m_pend_annul = 1'b0;
      m_owe_nop    = 1'b0;
   endtask

   // One clock with the given inputs; model advances at the edge, outputs checked 1ns later.
   task automatic step(input logic le, input logic ifl, input logic rd, input logic [31:0] tg,
                       input logic an, input string tag);
      logic        eff;
      logic [31:0] etgt;
      logic        eann;
      logic        nop_due;
      le_pc    = le;
      ifid_le  = ifl;
      redirect = rd;
      target   = tg;
      annul    = an;
      @(posedge clk);
      eff     = rd || m_pend;
      etgt    = rd ? (tg & 32'hFFFF_FFFC) : m_pend_tgt;
      eann    = rd ? an : m_pend_annul;
      nop_due = m_owe_nop || (le && eff && eann);
      if (ifl) begin
         m_ipc     = m_pc;
         m_inpc    = m_npc;
         m_instr   = nop_due ? NOP_WORD : mem_word(m_pc);
         m_valid   = !nop_due;
         m_owe_nop = 1'b0;
      end else begin
         m_owe_nop = nop_due;
      end
      if (le) begin
         if (eff) begin
            m_pc   = etgt;
            m_npc  = etgt + 32'd4;
            m_pend = 1'b0;
         end else begin
            m_pc  = m_npc;
            m_npc = m_npc + 32'd4;
         end
      end else if (rd) begin
         m_pend       = 1'b1;
         m_pend_tgt   = etgt;
         m_pend_annul = an;
      end
      #1;
      chk_all(tag);
   endtask

   initial begin
      reset    = 1'b1;
      le_pc    = 1'b0;
      ifid_le  = 1'b0;
      redirect = 1'b0;
      annul    = 1'b0;
      target   = 32'd0;
      model_reset();
      #12;
      chk_all("reset");
      reset = 1'b0;

      // Sequential fetch out of reset.
      step(1, 1, 0, 32'd0, 0, "seq0");
      chk("seq0.ifid_pc_lit", ifid_pc, 32'h0);
      step(1, 1, 0, 32'd0, 0, "seq1");
      chk("seq1.ifid_pc_lit", ifid_pc, 32'h4);
      step(1, 1, 0, 32'd0, 0, "seq2");
      chk("seq2.ifid_npc_lit", ifid_npc, 32'hC);
      step(1, 1, 0, 32'd0, 0, "seq3");

      // Non-annulled redirect at pc=0x10.
      step(1, 1, 1, 32'h0000_0100, 0, "br_slot");
      chk("br_slot.ifid_pc_lit", ifid_pc, 32'h10);
      chk("br_slot.pc_lit", pc, 32'h100);
      step(1, 1, 0, 32'd0, 0, "br_tgt");
      chk("br_tgt.ifid_pc_lit", ifid_pc, 32'h100);

      // Annulled redirect: slot becomes NOP but keeps its pc.
      step(1, 1, 0, 32'd0, 0, "pre_an");
      step(1, 1, 1, 32'h0000_0013, 1, "an_slot");
      chk("an_slot.instr_lit", ifid_instr, 32'h0100_0000);
      chk("an_slot.ifid_pc_lit", ifid_pc, 32'h108);
      step(1, 1, 0, 32'd0, 0, "an_tgt");
      chk("an_tgt.ifid_pc_lit", ifid_pc, 32'h10);

      // Redirect during a 3-cycle PC stall.
      step(0, 1, 1, 32'h0000_0200, 0, "stall0");
      step(0, 1, 0, 32'd0, 0, "stall1");
      step(0, 1, 0, 32'd0, 0, "stall2");
      step(1, 1, 0, 32'd0, 0, "stall_rel");
      chk("stall_rel.pc_lit", pc, 32'h200);
      chk("stall_rel.npc_lit", npc, 32'h204);

      // Latest pending redirect wins.
      step(0, 1, 1, 32'h0000_0300, 1, "pend_a");
      step(0, 1, 1, 32'h0000_0400, 0, "pend_b");
      step(1, 1, 0, 32'd0, 0, "pend_rel");

      // Annulled redirect while IF/ID is stalled for 2 cycles.
      step(1, 0, 1, 32'h0000_0500, 1, "sq0");
      step(1, 0, 0, 32'd0, 0, "sq1");
      step(1, 1, 0, 32'd0, 0, "sq_load");
      chk("sq_load.valid_lit", {31'd0, ifid_valid}, 32'd0);
      step(1, 1, 0, 32'd0, 0, "sq_after");

      // Wrap-around of PC/nPC.
      step(1, 1, 1, 32'hFFFF_FFFF, 0, "wrap_br");
      chk("wrap_br.npc_lit", npc, 32'h0);
      step(1, 1, 0, 32'd0, 0, "wrap_step");
      chk("wrap_step.pc_lit", pc, 32'h0);
      chk("wrap_step.npc_lit", npc, 32'h4);

      // Asynchronous reset mid-stall with a pending redirect.
      step(0, 0, 1, 32'h0000_0700, 1, "pre_rst");
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk_all("async_rst");
      reset = 1'b0;
      step(1, 1, 0, 32'd0, 0, "post_rst");
      chk("post_rst.pc_lit", pc, 32'h4);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         logic le_r, ifl_r, rd_r, an_r;
         le_r  = ($urandom_range(0, 3) != 0);
         ifl_r = ($urandom_range(0, 4) != 0);
         rd_r  = ($urandom_range(0, 4) == 0);
         an_r  = $urandom_range(0, 1) == 1;
         step(le_r, ifl_r, rd_r, $urandom, an_r, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
